// File: rtl/data_cache_pkg.sv
// Shared types and address-geometry helpers for the data cache.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } cache_state_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_SETS       = 64;
  localparam int DEF_LINE_WORDS = 4;

  // Bits selecting a word inside a line (0 for single-word lines).
  function automatic int word_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

  // Byte-offset plus word-select bits below the index field.
  function automatic int offset_bits(input int line_words);
    return 2 + word_bits(line_words);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
    return addr_w - offset_bits(line_words) - index_bits(sets);
  endfunction

  // Byte enables for a word access or a single-byte access at offset off.
  function automatic logic [3:0] byte_enable(input logic is_byte, input logic [1:0] off);
    return is_byte ? (4'b0001 << off) : 4'b1111;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side request/response channel of the data cache.
interface data_cache_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  // Requester side (pipeline memory stage).
  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Cache side.
  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/data_cache_line_array.sv
// Tag/valid/data storage: combinational read by index, byte-enabled word writes,
// valid bits cleared on reset. Tag and data contents are never reset.
module data_cache_line_array
  import data_cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [index_bits(SETS)-1:0]            rd_index,
  input  logic [((word_bits(LINE_WORDS) == 0) ? 1 : word_bits(LINE_WORDS))-1:0] rd_word,
  output logic                                   rd_valid,
  output logic [TAG_W-1:0]                       rd_tag,
  output logic [31:0]                            rd_data,
  input  logic                                   wr_en,
  input  logic [index_bits(SETS)-1:0]            wr_index,
  input  logic [((word_bits(LINE_WORDS) == 0) ? 1 : word_bits(LINE_WORDS))-1:0] wr_word,
  input  logic [3:0]                             wr_be,
  input  logic [31:0]                            wr_data,
  input  logic                                   tag_we,
  input  logic [TAG_W-1:0]                       wr_tag
);

  localparam int IDX_W  = index_bits(SETS);
  localparam int WB     = word_bits(LINE_WORDS);
  localparam int FLAT_W = IDX_W + WB;
  localparam int DEPTH  = SETS * LINE_WORDS;

  logic [SETS-1:0]   valid_reg;
  logic [TAG_W-1:0]  tag_mem [SETS];
  logic [FLAT_W-1:0] rd_flat;
  logic [FLAT_W-1:0] wr_flat;

  // Line-major word address; LINE_WORDS is a power of two so this is a concatenation.
  assign rd_flat = FLAT_W'(rd_index) * FLAT_W'(LINE_WORDS) + FLAT_W'(rd_word);
  assign wr_flat = FLAT_W'(wr_index) * FLAT_W'(LINE_WORDS) + FLAT_W'(wr_word);

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];

  // Valid bits: cleared on reset, set when a refill completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
    end else if (tag_we) begin
      valid_reg[wr_index] <= 1'b1;
    end
  end

  // Tag written together with the valid bit at the end of a refill.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  // One storage lane per byte so byte stores touch only their lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Byte-lane write when enabled.
      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) begin
          lane_mem[wr_flat] <= wr_data[8*gi +: 8];
        end
      end

      assign rd_data[8*gi +: 8] = lane_mem[rd_flat];
    end
  endgenerate

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill
// on load miss and hit/miss performance counters.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  data_cache_if.slave       cpu,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int WB     = word_bits(LINE_WORDS);
  localparam int WSEL_W = (WB == 0) ? 1 : WB;
  localparam int OFF_W  = offset_bits(LINE_WORDS);
  localparam int IDX_W  = index_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_W, SETS, LINE_WORDS);

  cache_state_t      state_reg;
  logic [WSEL_W-1:0] beat_reg;
  logic [ADDR_W-1:0] lat_addr_reg;
  logic              lat_byte_reg;
  logic              req_ready_reg;
  logic              rsp_valid_reg;
  logic [31:0]       rsp_rdata_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [3:0]        mem_be_reg;
  logic [31:0]       hit_count_reg;
  logic [31:0]       miss_count_reg;

  logic [IDX_W-1:0]  rd_index;
  logic [WSEL_W-1:0] rd_word;
  logic [TAG_W-1:0]  cur_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              lookup_hit;
  logic              last_beat;
  logic [WSEL_W-1:0] beat_next;

  logic              arr_wr_en;
  logic [WSEL_W-1:0] arr_wr_word;
  logic [3:0]        arr_wr_be;
  logic [31:0]       arr_wr_data;
  logic              arr_tag_we;

  // Word result or zero-extended byte at offset off.
  function automatic logic [31:0] pick(input logic [31:0] w, input logic b, input logic [1:0] off);
    return b ? ((w >> {off, 3'b000}) & 32'h0000_00FF) : w;
  endfunction

  // Lookup uses the live request while idle, the latched request otherwise.
  always_comb begin
    if (state_reg == IDLE) begin
      rd_index = cpu.req_addr[OFF_W +: IDX_W];
      rd_word  = (WB == 0) ? '0 : cpu.req_addr[2 +: WSEL_W];
      cur_tag  = cpu.req_addr[OFF_W + IDX_W +: TAG_W];
    end else begin
      rd_index = lat_addr_reg[OFF_W +: IDX_W];
      rd_word  = (WB == 0) ? '0 : lat_addr_reg[2 +: WSEL_W];
      cur_tag  = lat_addr_reg[OFF_W + IDX_W +: TAG_W];
    end
  end

  assign lookup_hit = rd_valid && (rd_tag == cur_tag);
  assign last_beat  = (beat_reg == WSEL_W'(LINE_WORDS - 1));
  assign beat_next  = beat_reg + 1'b1;

  // Array write port: refill beats write whole words, store hits write enabled bytes.
  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_word = (WB == 0) ? '0 : lat_addr_reg[2 +: WSEL_W];
    arr_wr_be   = mem_be_reg;
    arr_wr_data = mem_wdata_reg;
    arr_tag_we  = 1'b0;
    case (state_reg)
      REFILL: begin
        if (mem_ack) begin
          arr_wr_en   = 1'b1;
          arr_wr_word = beat_reg;
          arr_wr_be   = 4'b1111;
          arr_wr_data = mem_rdata;
          arr_tag_we  = last_beat;
        end
      end
      WRITE: begin
        arr_wr_en = mem_ack && lookup_hit;
      end
      default: ;
    endcase
  end

  data_cache_line_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .rd_index (rd_index),
    .rd_word  (rd_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_wr_en),
    .wr_index (lat_addr_reg[OFF_W +: IDX_W]),
    .wr_word  (arr_wr_word),
    .wr_be    (arr_wr_be),
    .wr_data  (arr_wr_data),
    .tag_we   (arr_tag_we),
    .wr_tag   (lat_addr_reg[OFF_W + IDX_W +: TAG_W])
  );

  // Control FSM with registered handshake, memory-bus and counter outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      lat_addr_reg   <= '0;
      lat_byte_reg   <= 1'b0;
      req_ready_reg  <= 1'b1;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_be_reg     <= 4'b0000;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu.req_valid) begin
            if (cpu.req_we) begin
              lat_addr_reg  <= cpu.req_addr;
              lat_byte_reg  <= cpu.req_byte;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= {cpu.req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata_reg <= cpu.req_byte ? {4{cpu.req_wdata[7:0]}} : cpu.req_wdata;
              mem_be_reg    <= byte_enable(cpu.req_byte, cpu.req_addr[1:0]);
              req_ready_reg <= 1'b0;
              state_reg     <= WRITE;
            end else if (lookup_hit) begin
              rsp_valid_reg <= 1'b1;
              rsp_rdata_reg <= pick(rd_data, cpu.req_byte, cpu.req_addr[1:0]);
              hit_count_reg <= hit_count_reg + 32'd1;
            end else begin
              lat_addr_reg   <= cpu.req_addr;
              lat_byte_reg   <= cpu.req_byte;
              miss_count_reg <= miss_count_reg + 32'd1;
              beat_reg       <= '0;
              mem_req_reg    <= 1'b1;
              mem_we_reg     <= 1'b0;
              mem_be_reg     <= 4'b1111;
              mem_addr_reg   <= {cpu.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              req_ready_reg  <= 1'b0;
              state_reg      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (last_beat) begin
              mem_req_reg <= 1'b0;
              mem_be_reg  <= 4'b0000;
              state_reg   <= RESP;
            end else begin
              beat_reg     <= beat_next;
              mem_addr_reg <= {lat_addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                              | ADDR_W'({beat_next, 2'b00});
            end
          end
        end
        RESP: begin
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= pick(rd_data, lat_byte_reg, lat_addr_reg[1:0]);
          req_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 4'b0000;
            rsp_valid_reg <= 1'b1;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu.req_ready = req_ready_reg;
  assign cpu.rsp_valid = rsp_valid_reg;
  assign cpu.rsp_rdata = rsp_rdata_reg;
  assign mem_req       = mem_req_reg;
  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign mem_be        = mem_be_reg;
  assign hit_count     = hit_count_reg;
  assign miss_count    = miss_count_reg;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: vector table plus hand-written sequences for
// back-to-back hits and reset during a refill. Memory acks two cycles after a request.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  data_cache_if #(.ADDR_W(32)) cpu_if ();

  data_cache #(.ADDR_W(32), .SETS(64), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu_if.slave),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mtx_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic        we;
    logic        by;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_tx;
    logic [3:0]  exp_be;
    logic [31:0] exp_hits;
    logic [31:0] exp_miss;
  } vec_t;

  logic [31:0] mem_model [logic [31:0]];
  mtx_t        mem_log [$];
  rsp_t        rsp_q [$];

  int          wait_cnt = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [3:0]  prev_be = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks every request two cycles after it appears.
  initial mem_ack = 1'b0;
  initial mem_rdata = '0;
  always @(negedge clk) begin
    if (reset) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (mem_req && prev_req && !prev_ack) begin
        checks++;
        if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata || mem_be !== prev_be) begin
          errors++;
          $display("FAIL mem_stable: got %h/%b/%h/%b expected %h/%b/%h/%b",
                   mem_addr, mem_we, mem_wdata, mem_be, prev_addr, prev_we, prev_wdata, prev_be);
        end
      end
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          mtx_t t;
          logic [31:0] cur;
          cur = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_model[mem_addr] = cur;
          end
          mem_rdata = cur;
          mem_ack   = 1'b1;
          t.addr = mem_addr; t.we = mem_we; t.be = mem_be; t.wdata = mem_wdata;
          mem_log.push_back(t);
        end
      end
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
      prev_be    = mem_be;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!reset && cpu_if.rsp_valid === 1'b1) begin
      rsp_t r;
      r.cyc  = cycle;
      r.data = cpu_if.rsp_rdata;
      rsp_q.push_back(r);
    end
  end

  // Present a request and hold it until accepted; returns the accepting edge number.
  task automatic issue(input vec_t v, output int acc_edge);
    int t = 0;
    cpu_if.req_valid = 1'b1;
    cpu_if.req_we    = v.we;
    cpu_if.req_byte  = v.by;
    cpu_if.req_addr  = v.addr;
    cpu_if.req_wdata = v.wdata;
    while (cpu_if.req_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (cpu_if.req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready=%b expected 1", cpu_if.req_ready);
    end
    acc_edge = cycle + 1;
    @(negedge clk);
    cpu_if.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output rsp_t r, output bit ok);
    int t = 0;
    #1;
    while (rsp_q.size() == 0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    ok = (rsp_q.size() > 0);
    if (ok) r = rsp_q.pop_front();
    else begin
      r.cyc = 0; r.data = '0;
      checks++; errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected a response");
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   acc;
    rsp_t r;
    bit   ok;
    mem_log.delete();
    rsp_q.delete();
    issue(v, acc);
    wait_rsp(r, ok);
    if (ok) begin
      if (!v.we) check($sformatf("v%0d rdata", idx), r.data, v.exp_rdata);
      if (!v.we && v.exp_tx == 0) check($sformatf("v%0d hit_latency", idx), r.cyc, acc);
    end
    check($sformatf("v%0d mem_tx", idx), mem_log.size(), v.exp_tx);
    if (!v.we && v.exp_tx == 4 && mem_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("v%0d beat%0d addr", idx, i), mem_log[i].addr, {v.addr[31:4], 4'h0} + 32'(4 * i));
        check($sformatf("v%0d beat%0d we", idx, i), 32'(mem_log[i].we), 32'd0);
      end
    end
    if (v.we && mem_log.size() == 1) begin
      check($sformatf("v%0d st_addr", idx), mem_log[0].addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d st_we", idx), 32'(mem_log[0].we), 32'd1);
      check($sformatf("v%0d st_be", idx), 32'(mem_log[0].be), 32'(v.exp_be));
      check($sformatf("v%0d st_wdata", idx), mem_log[0].wdata, v.by ? {4{v.wdata[7:0]}} : v.wdata);
    end
    check($sformatf("v%0d hit_count", idx), hit_count, v.exp_hits);
    check($sformatf("v%0d miss_count", idx), miss_count, v.exp_miss);
    @(negedge clk);
    #1;
    check($sformatf("v%0d rsp_pulse", idx), 32'(cpu_if.rsp_valid), 32'd0);
    $display("vec %0d we=%0b byte=%0b addr=%h rdata=%h tx=%0d hits=%0d misses=%0d",
             idx, v.we, v.by, v.addr, r.data, mem_log.size(), hit_count, miss_count);
  endtask

  function automatic vec_t mk(input logic we, input logic by, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int tx,
                              input logic [3:0] be, input logic [31:0] hits, input logic [31:0] miss);
    vec_t v;
    v.we = we; v.by = by; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata;
    v.exp_tx = tx; v.exp_be = be; v.exp_hits = hits; v.exp_miss = miss;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [15];
    vec_t v;
    rsp_t r;
    int   acc;
    int   t;

    mem_model[32'h100]  = 32'h1;        mem_model[32'h104]  = 32'h2;
    mem_model[32'h108]  = 32'h3;        mem_model[32'h10C]  = 32'h4;
    mem_model[32'h1100] = 32'hA0;       mem_model[32'h1104] = 32'hA1;
    mem_model[32'h1108] = 32'hA2;       mem_model[32'h110C] = 32'hA3;
    mem_model[32'h3000] = 32'hC0;       mem_model[32'h3004] = 32'hC1;
    mem_model[32'h3008] = 32'hC2;       mem_model[32'h300C] = 32'hC3;

    //            we    by    addr        wdata         rdata         tx  be       hits miss
    vecs[0]  = mk(1'b0, 1'b0, 32'h100,  32'h0,        32'h1,        4, 4'b0000, 0, 1);
    vecs[1]  = mk(1'b0, 1'b0, 32'h108,  32'h0,        32'h3,        0, 4'b0000, 1, 1);
    vecs[2]  = mk(1'b0, 1'b0, 32'h104,  32'h0,        32'h2,        0, 4'b0000, 2, 1);
    vecs[3]  = mk(1'b1, 1'b0, 32'h104,  32'hDEADBEEF, 32'h0,        1, 4'b1111, 2, 1);
    vecs[4]  = mk(1'b0, 1'b0, 32'h104,  32'h0,        32'hDEADBEEF, 0, 4'b0000, 3, 1);
    vecs[5]  = mk(1'b1, 1'b0, 32'h2000, 32'h12345678, 32'h0,        1, 4'b1111, 3, 1);
    vecs[6]  = mk(1'b0, 1'b0, 32'h2000, 32'h0,        32'h12345678, 4, 4'b0000, 3, 2);
    vecs[7]  = mk(1'b0, 1'b0, 32'h1100, 32'h0,        32'hA0,       4, 4'b0000, 3, 3);
    vecs[8]  = mk(1'b0, 1'b0, 32'h100,  32'h0,        32'h1,        4, 4'b0000, 3, 4);
    vecs[9]  = mk(1'b1, 1'b0, 32'h100,  32'h11223344, 32'h0,        1, 4'b1111, 3, 4);
    vecs[10] = mk(1'b0, 1'b1, 32'h101,  32'h0,        32'h33,       0, 4'b0000, 4, 4);
    vecs[11] = mk(1'b1, 1'b1, 32'h102,  32'hFFFFFFAB, 32'h0,        1, 4'b0100, 4, 4);
    vecs[12] = mk(1'b0, 1'b0, 32'h100,  32'h0,        32'h11AB3344, 0, 4'b0000, 5, 4);
    vecs[13] = mk(1'b0, 1'b1, 32'h103,  32'h0,        32'h11,       0, 4'b0000, 6, 4);
    vecs[14] = mk(1'b0, 1'b1, 32'h2003, 32'h0,        32'h12,       0, 4'b0000, 7, 4);

    cpu_if.req_valid = 1'b0;
    cpu_if.req_we    = 1'b0;
    cpu_if.req_byte  = 1'b0;
    cpu_if.req_addr  = '0;
    cpu_if.req_wdata = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(cpu_if.req_ready), 32'd1);
    check("rst rsp_valid", 32'(cpu_if.rsp_valid), 32'd0);
    check("rst rsp_rdata", cpu_if.rsp_rdata, 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_be", 32'(mem_be), 32'd0);
    check("rst hit_count", hit_count, 32'd0);
    check("rst miss_count", miss_count, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Three back-to-back hits: one response per cycle, no memory traffic.
    mem_log.delete();
    rsp_q.delete();
    acc = cycle + 1;
    check("b2b ready", 32'(cpu_if.req_ready), 32'd1);
    cpu_if.req_valid = 1'b1; cpu_if.req_we = 1'b0; cpu_if.req_byte = 1'b0;
    cpu_if.req_addr = 32'h100;
    @(negedge clk); cpu_if.req_addr = 32'h104;
    @(negedge clk); cpu_if.req_addr = 32'h108;
    @(negedge clk); cpu_if.req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("b2b count", rsp_q.size(), 32'd3);
    if (rsp_q.size() == 3) begin
      check("b2b data0", rsp_q[0].data, 32'h11AB3344);
      check("b2b data1", rsp_q[1].data, 32'hDEADBEEF);
      check("b2b data2", rsp_q[2].data, 32'h3);
      check("b2b cyc0", rsp_q[0].cyc, acc);
      check("b2b cyc1", rsp_q[1].cyc, acc + 1);
      check("b2b cyc2", rsp_q[2].cyc, acc + 2);
    end
    check("b2b mem_tx", mem_log.size(), 32'd0);
    check("b2b hit_count", hit_count, 32'd10);
    $display("b2b hits responses=%0d hits=%0d misses=%0d", rsp_q.size(), hit_count, miss_count);

    // Reset asserted while the refill is on its third beat.
    mem_log.delete();
    rsp_q.delete();
    v = mk(1'b0, 1'b0, 32'h3000, 32'h0, 32'h0, 4, 4'b0000, 0, 0);
    issue(v, acc);
    t = 0;
    #1;
    while (mem_log.size() < 2 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("mid reached beat2", mem_log.size(), 32'd2);
    @(negedge clk);
    #1;
    check("mid beat2 addr", mem_addr, 32'h3008);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid mem_req", 32'(mem_req), 32'd0);
    check("mid req_ready", 32'(cpu_if.req_ready), 32'd1);
    check("mid hit_count", hit_count, 32'd0);
    check("mid miss_count", miss_count, 32'd0);
    $display("reset mid-refill mem_req=%0b hits=%0d misses=%0d", mem_req, hit_count, miss_count);
    reset = 1'b0;
    @(negedge clk);
    #1;
    run_vec(mk(1'b0, 1'b0, 32'h100,  32'h0, 32'h11AB3344, 4, 4'b0000, 0, 1), 15);
    run_vec(mk(1'b0, 1'b0, 32'h3004, 32'h0, 32'hC1,       4, 4'b0000, 0, 2), 16);

    // Write-through reached memory.
    check("mem 0x100", mem_model[32'h100], 32'h11AB3344);
    check("mem 0x104", mem_model[32'h104], 32'hDEADBEEF);
    check("mem 0x2000", mem_model[32'h2000], 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
